mdu_iter: RTL and testbench

- Iterative multiply/divide unit. Sits directly downstream of the register file: it consumes the two register read ports (RD1 as rs, RD2 as rt).
- Produces the architectural HI/LO pair. HI/LO are read back by MFHI/MFLO and sent to the register-file write-data mux.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO with a start/busy/done handshake, so the core can stall while an operation runs.

---
 rtl/mdu_iter.sv | 172 +++++++++++++++++
 tb/tb_mdu_iter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit producing the architectural HI/LO pair.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Each runs on
// unsigned magnitudes for W clocks, followed by one sign fix-up clock.
// MTHI/MTLO write HI/LO directly when the unit is idle.
module mdu_iter #(
  parameter int W  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] rs,
  input  logic [W-1:0] rt,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   work_q, work_d;   // {acc, multiplier} or {remainder, quotient}
  logic [W-1:0]     opb_q, opb_d;     // multiplicand or divisor magnitude
  logic [W-1:0]     rs_q, rs_d;       // original rs, returned as HI on divide by zero
  logic             is_div_q, is_div_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             done_q, done_d;

  // Datapath intermediates
  logic             sgn;
  logic [W-1:0]     a_mag, b_mag;
  logic [W:0]       mul_sum;
  logic [2*W-1:0]   mul_next;
  logic [W:0]       div_shl;
  logic [W-1:0]     div_diff;
  logic             div_ge;
  logic [2*W-1:0]   div_next;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     quo, rem;

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // State and datapath registers; reset aborts any operation in flight.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opb_q    <= '0;
      rs_q     <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opb_q    <= opb_d;
      rs_q     <= rs_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // Next-state, iteration step and sign fix-up.
  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opb_d    = opb_q;
    rs_d     = rs_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    // Operand magnitudes for signed ops
    sgn   = (op == OP_MULT) || (op == OP_DIV);
    a_mag = (sgn && rs[W-1]) ? -rs : rs;
    b_mag = (sgn && rt[W-1]) ? -rt : rt;

    // Shift-add step: add multiplicand when the multiplier LSB is set, then shift right
    mul_sum  = {1'b0, work_q[2*W-1:W]} + {1'b0, (work_q[0] ? opb_q : {W{1'b0}})};
    mul_next = {mul_sum, work_q[W-1:1]};

    // Restoring step: shift left, subtract divisor if it fits, shift in quotient bit
    div_shl  = {work_q[2*W-1:W], work_q[W-1]};
    div_ge   = (div_shl >= {1'b0, opb_q});
    div_diff = div_shl[W-1:0] - opb_q;
    div_next = div_ge ? {div_diff, work_q[W-2:0], 1'b1}
                      : {div_shl[W-1:0], work_q[W-2:0], 1'b0};

    // Sign fix-up candidates
    prod_fix = (neg_a_q ^ neg_b_q) ? -work_q : work_q;
    quo      = (neg_a_q ^ neg_b_q) ? -work_q[W-1:0] : work_q[W-1:0];
    rem      = neg_a_q ? -work_q[2*W-1:W] : work_q[2*W-1:W];

    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d = op[1];
              neg_a_d  = sgn && rs[W-1];
              neg_b_d  = sgn && rt[W-1];
              rs_d     = rs;
              work_d   = op[1] ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
              opb_d    = op[1] ? b_mag : a_mag;
              cnt_d    = '0;
              state_d  = CALC;
            end
            OP_MTHI: hi_d = rs;
            OP_MTLO: lo_d = rs;
            default: ;
          endcase
        end
      end
      CALC: begin
        work_d = is_div_q ? div_next : mul_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        if (is_div_q) begin
          if (opb_q == '0) begin
            lo_d = {W{1'b1}};
            hi_d = rs_q;
          end else begin
            lo_d = quo;
            hi_d = rem;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: the driver queues expected HI/LO per
// mult/div, and a monitor compares them whenever done pulses.
module tb_mdu_iter;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;
  localparam logic [2:0] NOP   = 3'b110;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  logic        clk, clr, start;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done;
  logic [31:0] hi, lo;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  mdu_iter #(.W(32), .CW(6)) dut (
    .clk  (clk),
    .clr  (clr),
    .start(start),
    .op   (op),
    .rs   (rs),
    .rt   (rt),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare HI/LO against the oldest expectation on each done pulse
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
          check({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
        end
      end
    end
  end

  // Issue one mult/div; optionally inject an MTHI start at sample cycle inj
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input string nm, input int inj);
    int cyc;
    int busy_n;
    sb.push_back('{eh, el, nm});
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0; rs = 32'hDEADBEEF ^ a; rt = ~b;
    cyc = 1;
    busy_n = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) busy_n++;
      if (cyc == inj) begin
        start = 1'b1; op = MTHI; rs = 32'h0000_1234;
      end else if (cyc == inj + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({nm, "_latency"}, 64'(cyc), 64'd34);
    check({nm, "_busy_cycles"}, 64'(busy_n), 64'd33);
    check({nm, "_busy_off"}, {63'd0, busy}, 64'd0);
    @(negedge clk);
    check({nm, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int dn;
    clr = 1'b0; start = 1'b0; op = NOP; rs = '0; rt = '0;
    #2;
    check("rst_hi",   {32'd0, hi}, 64'd0);
    check("rst_lo",   {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    repeat (2) @(negedge clk);
    clr = 1'b1;

    run_op(MULTU, 32'd70, 32'd101, 32'h0000_0000, 32'h0000_1B9E, "multu_70x101", 0);
    run_op(MULT,  32'hFFFF_FEA9, 32'd101, 32'hFFFF_FFFF, 32'hFFFF_78AD, "mult_neg", 0);
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0);
    run_op(MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_m1xm1", 0);
    run_op(DIV,   32'hFFFF_FEA9, 32'd70, 32'hFFFF_FFC1, 32'hFFFF_FFFC, "div_neg", 0);
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf", 0);
    run_op(DIV,   32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_m2", 0);
    run_op(DIVU,  32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7", 0);
    run_op(DIVU,  32'd343, 32'd0, 32'h0000_0157, 32'hFFFF_FFFF, "divu_by0", 0);
    run_op(DIV,   32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_by0", 0);
    run_op(DIVU,  32'd343, 32'd70, 32'd63, 32'd4, "divu_busy_mthi", 10);

    // Idle MTLO / MTHI / no-op
    @(negedge clk);
    start = 1'b1; op = MTLO; rs = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo",   {32'd0, lo}, 64'h0000_DEAD);
    check("mtlo_hi",   {32'd0, hi}, 64'd63);
    check("mtlo_busy", {63'd0, busy}, 64'd0);
    check("mtlo_done", {63'd0, done}, 64'd0);
    start = 1'b1; op = MTHI; rs = 32'h0000_BEEF;
    @(negedge clk);
    start = 1'b0;
    check("mthi_hi",   {32'd0, hi}, 64'h0000_BEEF);
    check("mthi_busy", {63'd0, busy}, 64'd0);
    start = 1'b1; op = NOP; rs = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    check("nop_hilo", {hi, lo}, {32'h0000_BEEF, 32'h0000_DEAD});
    check("nop_busy", {63'd0, busy}, 64'd0);

    // Reset mid-MULT at cycle 15
    start = 1'b1; op = MULT; rs = 32'd12345; rt = 32'd678;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    clr = 1'b0;
    #1;
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    clr = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    check("post_rst_no_done", 64'(dn), 64'd0);
    check("post_rst_hilo", {hi, lo}, 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
